// File: rtl/float_mul_pkg.sv
// Shared definitions for the single-precision multiplier.
// Field widths, IEEE-754 constants, the packed float view and the FSM state type.
package float_mul_pkg;

  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } float_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_MUL,
    S_NORM,
    S_ROUND
  } fmul_state_t;

endpackage

// File: rtl/float_mul_if.sv
// start/ready handshake bundle for float_mul.
//   start     : request, sampled by the multiplier only while idle
//   float_a/b : IEEE-754 single operands, captured with an accepted start
//   float_out : product, held until the next result is written
//   ready     : one-cycle pulse, float_out valid from this cycle on
// master = requester side, slave = multiplier side.
interface float_mul_if;
  logic        start;
  logic [31:0] float_a;
  logic [31:0] float_b;
  logic [31:0] float_out;
  logic        ready;

  modport master (output start, output float_a, output float_b,
                  input  float_out, input ready);
  modport slave  (input  start, input  float_a, input  float_b,
                  output float_out, output ready);
endinterface

// File: rtl/float_mul_mant_mul_iter.sv
// Iterative shift-add 24x24 -> 48-bit unsigned mantissa multiplier.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture mant_a/mant_b and clear the accumulator
//   step     : retire STEP multiplier bits into the accumulator
//   mant_a/b : 24-bit mantissas (hidden bit included)
//   prod     : 48-bit product, complete after 24/STEP steps
//   done     : the step taken this cycle is the final one
module mant_mul_iter #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] mant_a,
  input  logic [23:0] mant_b,
  output logic [47:0] prod,
  output logic        done
);
  localparam int unsigned NSTEPS = 24 / STEP;
  localparam int unsigned CNT_W  = $clog2(NSTEPS) + 1;

  logic [47:0]      acc_q, acc_d;
  logic [47:0]      mcand_q, mcand_d;
  logic [23:0]      mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {24'b0, mant_a};
      mplier_d = mant_b;
      cnt_d    = '0;
    end else if (step) begin
      for (int unsigned i = 0; i < STEP; i++) begin
        if (mplier_q[i]) acc_d = acc_d + (mcand_q << i);
      end
      mcand_d  = mcand_q << STEP;
      mplier_d = mplier_q >> STEP;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod = acc_q;
  // Asserted during the last step so the caller leaves MUL exactly as the
  // product lands in the accumulator.
  assign done = (cnt_q == CNT_W'(NSTEPS - 1));

endmodule

// File: rtl/float_mul.sv
// Sequential IEEE-754 single-precision multiplier (start/ready handshake).
//   clk  : clock, all state updates on rising edge
//   rst  : synchronous active-high reset
//   bus  : float_mul_if.slave -- start, float_a, float_b in; float_out, ready out
// Fixed latency L = 24/MUL_STEP + 3 from the accepting edge to the ready cycle,
// special operands included; a start held high chains operations every L+1.
module float_mul
  import float_mul_pkg::*;
#(
  parameter int unsigned MUL_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  float_mul_if.slave bus
);
  fmul_state_t       state_q, state_d;
  float_t            a_q, a_d, b_q, b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic              special_q, special_d;
  logic [31:0]       special_val_q, special_val_d;
  logic [23:0]       mant_q, mant_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       float_out_q, float_out_d;
  logic              ready_q, ready_d;

  logic              mul_load, mul_step, mul_done;
  logic [47:0]       prod;

  // Operand decode (used in UNPACK).
  logic              a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic              sign_u, special_u;
  logic signed [9:0] exp_u;
  logic [31:0]       special_val_u;
  logic [23:0]       mant_a_u, mant_b_u;

  always_comb begin
    // Exponent 0 covers both zero and denormals: both flush to signed zero.
    a_zero = (a_q.exp == '0);
    b_zero = (b_q.exp == '0);
    a_inf  = (a_q.exp == '1) && (a_q.frac == '0);
    b_inf  = (b_q.exp == '1) && (b_q.frac == '0);
    a_nan  = (a_q.exp == '1) && (a_q.frac != '0);
    b_nan  = (b_q.exp == '1) && (b_q.frac != '0);
    sign_u = a_q.sign ^ b_q.sign;
    exp_u  = {2'b00, a_q.exp} + {2'b00, b_q.exp} - 10'(EXP_BIAS);
    mant_a_u = {1'b1, a_q.frac};
    mant_b_u = {1'b1, b_q.frac};
    special_u     = 1'b0;
    special_val_u = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      special_u     = 1'b1;
      special_val_u = QNAN;
    end else if (a_inf || b_inf) begin
      special_u     = 1'b1;
      special_val_u = POS_INF | {sign_u, 31'b0};
    end else if (a_zero || b_zero) begin
      special_u     = 1'b1;
      special_val_u = {sign_u, 31'b0};
    end
  end

  // Round-to-nearest-even and range clamp (used in ROUND).
  logic              round_up;
  logic [24:0]       mant_r;
  logic signed [9:0] exp_r;
  logic [22:0]       frac_r;
  logic [31:0]       result;

  always_comb begin
    round_up = guard_q & (sticky_q | mant_q[0]);
    mant_r   = {1'b0, mant_q} + {24'b0, round_up};
    exp_r    = exp_q + {9'b0, mant_r[24]};
    // On carry-out the rounded mantissa is exactly 2.0, so the fraction is 0.
    frac_r   = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    if (special_q)                result = special_val_q;
    else if (exp_r >= 10'sd255)   result = POS_INF | {sign_q, 31'b0};
    else if (exp_r <= 10'sd0)     result = {sign_q, 31'b0};
    else                          result = {sign_q, exp_r[7:0], frac_r};
  end

  mant_mul_iter #(
    .STEP (MUL_STEP)
  ) u_mant (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .step   (mul_step),
    .mant_a (mant_a_u),
    .mant_b (mant_b_u),
    .prod   (prod),
    .done   (mul_done)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sign_d        = sign_q;
    exp_d         = exp_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    mant_d        = mant_q;
    guard_d       = guard_q;
    sticky_d      = sticky_q;
    float_out_d   = float_out_q;
    ready_d       = 1'b0;
    mul_load      = 1'b0;
    mul_step      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.float_a;
          b_d     = bus.float_b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        mul_load      = 1'b1;
        sign_d        = sign_u;
        exp_d         = exp_u;
        special_d     = special_u;
        special_val_d = special_val_u;
        state_d       = S_MUL;
      end
      S_MUL: begin
        mul_step = 1'b1;
        if (mul_done) state_d = S_NORM;
      end
      S_NORM: begin
        if (prod[47]) begin
          mant_d   = prod[47:24];
          guard_d  = prod[23];
          sticky_d = |prod[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          mant_d   = prod[46:23];
          guard_d  = prod[22];
          sticky_d = |prod[21:0];
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        // Completion is registered on the ROUND exit: the ready cycle is the
        // IDLE cycle, so a held start is accepted on the very next edge.
        float_out_d = result;
        ready_d     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      exp_q         <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      mant_q        <= '0;
      guard_q       <= 1'b0;
      sticky_q      <= 1'b0;
      float_out_q   <= '0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sign_q        <= sign_d;
      exp_q         <= exp_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      mant_q        <= mant_d;
      guard_q       <= guard_d;
      sticky_q      <= sticky_d;
      float_out_q   <= float_out_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.float_out = float_out_q;
  assign bus.ready     = ready_q;

endmodule

// File: tb/tb_float_mul.sv
// Self-checking bench for float_mul: directed vectors with literal expectations,
// plus a protocol-level reference model compared against the outputs every cycle.
module tb_float_mul;
  localparam int unsigned STEP    = 1;
  localparam int          L       = 24 / STEP + 3;
  localparam int          TIMEOUT = 200;
  localparam int          NV      = 17;

  logic clk;
  logic rst;
  float_mul_if bus();

  float_mul #(.MUL_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ready_count = 0;
  bit cmp_en = 0;

  logic [31:0] va [NV] = '{32'h40000000, 32'hC0000000, 32'h3F800001, 32'h3F99999A,
                           32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h7F000000,
                           32'h00800000, 32'h00000001, 32'h3FC00000, 32'h3FC00000,
                           32'h3FC00000, 32'h80000000, 32'h7F800000, 32'h3FFFFFFE,
                           32'h00800000};
  logic [31:0] vb [NV] = '{32'h40400000, 32'h40400000, 32'h3F800001, 32'h3F000000,
                           32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F000000,
                           32'h00800000, 32'h40000000, 32'h3FC00000, 32'h3F800001,
                           32'h3F800003, 32'h3F800000, 32'hFF800000, 32'h3F800001,
                           32'h3F000000};
  logic [31:0] ve [NV] = '{32'h40C00000, 32'hC0C00000, 32'h3F800002, 32'h3F19999A,
                           32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                           32'h00000000, 32'h00000000, 32'h40100000, 32'h3FC00002,
                           32'h3FC00004, 32'h80000000, 32'hFF800000, 32'h40000000,
                           32'h00000000};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
    end
  endtask

  // Reference product from IEEE rules using plain integer arithmetic.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, az, bz, ai, bi, an, bn;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, q, r, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 255) && (a[22:0] == 23'd0);
    bi = (eb == 255) && (b[22:0] == 23'd0);
    an = (ea == 255) && (a[22:0] != 23'd0);
    bn = (eb == 255) && (b[22:0] != 23'd0);
    if (an || bn || (ai && bz) || (az && bi)) return 32'h7FC00000;
    if (ai || bi) return {s, 8'hFF, 23'd0};
    if (az || bz) return {s, 31'd0};
    ma = {40'd0, 1'b1, a[22:0]};
    mb = {40'd0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
    else sh = 23;
    q    = p >> sh;
    r    = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 1;
    if (q >= (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  // Protocol-level model: an op accepted at edge E yields ready after edge E+L;
  // the next op can be accepted from edge E+L+1.
  int          m_cyc = 0;
  int          m_due = 0;
  bit          m_busy = 0;
  bit          m_ready_exp = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_out = '0;

  initial begin
    bit was_busy;
    forever begin
      @(posedge clk);
      m_cyc++;
      if (rst) begin
        m_busy = 0;
        m_out = '0;
        m_ready_exp = 0;
      end else begin
        was_busy = m_busy;
        m_ready_exp = 0;
        if (m_busy && m_cyc == m_due) begin
          m_out = m_res;
          m_ready_exp = 1;
          m_busy = 0;
        end
        if (!was_busy && bus.start) begin
          m_busy = 1;
          m_due  = m_cyc + L;
          m_res  = ref_mul(bus.float_a, bus.float_b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.ready) ready_count++;
      if (cmp_en) begin
        chk("model_ready", 32'(bus.ready), 32'(m_ready_exp));
        chk("model_out", bus.float_out, m_out);
      end
    end
  end

  // Single op; latency n counts negedges from the one where start is raised,
  // so ready after edge E+L shows up at n = L+1.
  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    int n;
    @(negedge clk);
    bus.float_a = a;
    bus.float_b = b;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.float_a = $urandom();
    bus.float_b = $urandom();
    n = 1;
    while (!bus.ready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) begin
      chk({name, "_timeout"}, 32'(n), 32'(L + 1));
    end else begin
      chk({name, "_latency"}, 32'(n), 32'(L + 1));
      chk(name, bus.float_out, e);
    end
  endtask

  initial begin
    int n, rc;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.float_a = '0;
    bus.float_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(bus.ready), 32'h0);
    chk("reset_out", bus.float_out, 32'h0);
    rst = 1'b0;
    cmp_en = 1;

    for (int i = 0; i < NV; i++) do_op($sformatf("vec%0d", i), va[i], vb[i], ve[i]);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.float_a = va[0];
    bus.float_b = vb[0];
    bus.start   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.ready && n < TIMEOUT);
      chk($sformatf("b2b%0d_gap", k), 32'(n), 32'(L + 1));
      chk($sformatf("b2b%0d", k), bus.float_out, ve[k]);
      if (k < 9) begin
        bus.float_a = va[k + 1];
        bus.float_b = vb[k + 1];
      end else begin
        bus.start = 1'b0;
      end
      if (n >= TIMEOUT) break;
    end

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.float_a = 32'h40000000;
    bus.float_b = 32'h40400000;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    rc = ready_count;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out", bus.float_out, 32'h0);
    repeat (40) @(negedge clk);
    chk("midrst_no_ready", 32'(ready_count - rc), 32'h0);
    chk("midrst_out_held", bus.float_out, 32'h0);

    // rst and start together: rst wins.
    @(negedge clk);
    bus.float_a = 32'h3F800000;
    bus.float_b = 32'h40000000;
    bus.start   = 1'b1;
    rst         = 1'b1;
    rc = ready_count;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (35) @(negedge clk);
    chk("rst_start_no_ready", 32'(ready_count - rc), 32'h0);

    do_op("after_rst", 32'h3FC00000, 32'h3F800001, 32'h3FC00002);
    do_op("max_normal", 32'h3F800000, 32'h7F7FFFFF, 32'h7F7FFFFF);
    do_op("min_normal", 32'h00800000, 32'h3F800000, 32'h00800000);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
